// File: rtl/neuromorphic_xn_pkg.sv
// Shared types and helpers for the neuromorphic crossbar array stand-in.
// Field-split constants describe the default 32x32 geometry of the macro.
package neuromorphic_xn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } xn_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEFAULT_ROWS = 32;
    localparam int DEFAULT_COLS = 32;
    localparam int DEFAULT_RAW  = clog2(DEFAULT_ROWS);
    localparam int DEFAULT_CAW  = clog2(DEFAULT_COLS);
    localparam int DEFAULT_AW   = DEFAULT_RAW + DEFAULT_CAW;

endpackage

// File: rtl/xn_write_fifo.sv
// Posted-write queue: synchronous FIFO with first-word-fall-through head.
// A push into a full queue is legal only when a pop happens in the same cycle.
module xn_write_fifo
    import neuromorphic_xn_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH),
    localparam int LW   = clog2(DEPTH) + 1
)(
    input  logic             CLKin,
    input  logic             RSTin,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;

    // Storage carries no reset; discarding entries only needs the pointers.
    always_ff @(posedge CLKin) begin
        if (push) mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      level_reg <= level_reg + 1'b1;
            else if (pop && !push) level_reg <= level_reg - 1'b1;
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
    assign level = level_reg;

endmodule

// File: rtl/neuromorphic_xn_array.sv
// Cycle-accurate stand-in for the ReRAM crossbar: posted writes are programmed
// one cell per WR_LAT cycles; reads wait for an idle engine and respond after RD_LAT+1.
module neuromorphic_xn_array
    import neuromorphic_xn_pkg::*;
#(
    parameter int ROWS     = 32,
    parameter int COLS     = 32,
    parameter int DW       = 8,
    parameter int WQ_DEPTH = 4,
    parameter int WR_LAT   = 4,
    parameter int RD_LAT   = 2,
    localparam int RAW     = clog2(ROWS),
    localparam int CAW     = clog2(COLS),
    localparam int AW      = RAW + CAW,
    localparam int LW      = clog2(WQ_DEPTH) + 1
)(
    input  logic          CLKin,
    input  logic          RSTin,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          wr_err,
    output logic          busy,
    output logic [LW-1:0] wq_level
);

    localparam int IW      = clog2(ROWS * COLS);
    localparam int MAX_LAT = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int CW      = clog2(MAX_LAT + 1);

    xn_state_e         state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [AW-1:0]     prog_addr_reg;
    logic [DW-1:0]     prog_data_reg;
    logic [AW-1:0]     rd_addr_reg;
    logic              rsp_valid_reg;
    logic              rsp_err_reg;
    logic [DW-1:0]     rsp_rdata_reg;
    logic              wr_err_reg;
    logic [DW-1:0]     cells [ROWS*COLS];

    logic              fifo_full, fifo_empty;
    logic [AW+DW-1:0]  fifo_head;
    logic              push, pop, rd_acc, commit;

    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return (int'(a[AW-1:CAW]) < ROWS) && (int'(a[CAW-1:0]) < COLS);
    endfunction

    function automatic logic [IW-1:0] cell_index(input logic [AW-1:0] a);
        return IW'(int'(a[AW-1:CAW]) * COLS + int'(a[CAW-1:0]));
    endfunction

    xn_write_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (WQ_DEPTH)
    ) u_write_fifo (
        .CLKin (CLKin),
        .RSTin (RSTin),
        .push  (push),
        .pop   (pop),
        .wdata ({req_addr, req_wdata}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (wq_level)
    );

    // The engine pops when idle or in the commit cycle, so programming runs back-to-back.
    assign commit    = (state_reg == PROG) && (cnt_reg == '0);
    assign pop       = !fifo_empty && ((state_reg == IDLE) || commit);
    assign req_ready = req_we ? (!fifo_full || pop) : ((state_reg == IDLE) && fifo_empty);
    assign push      = req_valid && req_ready && req_we;
    assign rd_acc    = req_valid && req_ready && !req_we;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next = PROG;
                    cnt_next   = CW'(WR_LAT - 1);
                end else if (rd_acc) begin
                    state_next = READ;
                    cnt_next   = CW'(RD_LAT - 1);
                end
            end
            PROG: begin
                if (cnt_reg != '0)  cnt_next = cnt_reg - 1'b1;
                else if (pop)       cnt_next = CW'(WR_LAT - 1);
                else                state_next = IDLE;
            end
            READ: begin
                if (cnt_reg != '0)  cnt_next = cnt_reg - 1'b1;
                else                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            prog_addr_reg <= '0;
            prog_data_reg <= '0;
            rd_addr_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            wr_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            if (pop) begin
                prog_addr_reg <= fifo_head[AW+DW-1:DW];
                prog_data_reg <= fifo_head[DW-1:0];
            end
            if (rd_acc) rd_addr_reg <= req_addr;
            wr_err_reg    <= push && !addr_in_range(req_addr);
            rsp_valid_reg <= (state_reg == RESP);
            if (state_reg == RESP) begin
                rsp_err_reg   <= !addr_in_range(rd_addr_reg);
                rsp_rdata_reg <= addr_in_range(rd_addr_reg) ? cells[cell_index(rd_addr_reg)] : '0;
            end
        end
    end

    // Array contents survive reset; an aborted program never reaches its commit cycle.
    always_ff @(posedge CLKin) begin
        if (commit && addr_in_range(prog_addr_reg))
            cells[cell_index(prog_addr_reg)] <= prog_data_reg;
    end

    assign busy      = (state_reg != IDLE) || !fifo_empty;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign wr_err    = wr_err_reg;

endmodule

// File: tb/tb_neuromorphic_xn_array.sv
// Scoreboard bench: the driver queues expected responses from a cell-level model,
// independent monitors compare read responses and write-error pulses.
module tb_neuromorphic_xn_array;

    localparam int ROWS = 30, COLS = 20, DW = 8, WQ = 4, WR_LAT = 4, RD_LAT = 2;
    localparam int CAW = 5, AW = 10, LW = 3;

    logic          CLKin = 1'b0;
    logic          RSTin;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err, wr_err, busy;
    logic [DW-1:0] rsp_rdata;
    logic [LW-1:0] wq_level;

    neuromorphic_xn_array #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .WQ_DEPTH(WQ), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
    ) dut (
        .CLKin(CLKin), .RSTin(RSTin), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wr_err(wr_err), .busy(busy), .wq_level(wq_level)
    );

    always #5 CLKin = ~CLKin;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            acc;
    } rsp_t;

    rsp_t          rsp_q[$];
    bit            wr_exp_q[$];
    logic [DW-1:0] model[int];
    int            written[$];
    int            cycle = 0;
    int            checks = 0, passes = 0;
    int            last_acc, last_stall, max_level;
    logic          acc_w_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic flag_fail(input string name);
        checks++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cycle);
    endtask

    always @(posedge CLKin) begin
        cycle      <= cycle + 1;
        acc_w_prev <= req_valid && req_ready && req_we && !RSTin;
    end

    // Monitor: write-error pulses and read responses.
    always @(negedge CLKin) begin
        if (!RSTin) begin
            if (acc_w_prev) begin
                if (wr_exp_q.size() == 0) flag_fail("wr_err_queue");
                else check("wr_err", 32'(wr_err), 32'(wr_exp_q.pop_front()));
            end else if (wr_err) begin
                check("wr_err_spurious", 32'(wr_err), 32'd0);
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) check("rsp_spurious", 32'(rsp_valid), 32'd0);
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_latency", 32'(cycle - e.acc), 32'(RD_LAT + 1));
                    $display("rsp: data=%0h err=%0b at cycle %0d", rsp_rdata, rsp_err, cycle);
                end
            end
            if (int'(wq_level) > max_level) max_level = int'(wq_level);
            if (int'(wq_level) > WQ) check("wq_level_bound", 32'(wq_level), 32'(WQ));
        end
    end

    task automatic issue(input bit we, input int row, input int col,
                         input logic [DW-1:0] d, input bit upd);
        int   key, stall;
        bit   inr;
        rsp_t e;
        key = row * 32 + col;
        inr = (row < ROWS) && (col < COLS);
        stall = 0;
        req_valid = 1'b1; req_we = we; req_wdata = d;
        req_addr  = AW'((row << CAW) | col);
        #1;
        while (!req_ready) begin
            stall++;
            @(negedge CLKin); #1;
            if (stall > 200) begin
                flag_fail("req_ready_timeout");
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge CLKin);
        if (we) begin
            wr_exp_q.push_back(!inr);
            if (upd && inr) begin
                if (!model.exists(key)) written.push_back(key);
                model[key] = d;
            end
        end else begin
            e.err  = !inr;
            e.data = inr ? model[key] : '0;
        end
        @(negedge CLKin);
        last_acc   = cycle;
        last_stall = stall;
        req_valid  = 1'b0;
        if (!we) begin
            e.acc = cycle;
            rsp_q.push_back(e);
        end
        $display("req: we=%0b row=%0d col=%0d data=%0h stall=%0d cycle=%0d", we, row, col, d, stall, cycle);
    endtask

    task automatic wait_idle(output int at);
        int g;
        g = 0;
        while (busy) begin
            @(negedge CLKin);
            g++;
            if (g > 500) begin flag_fail("busy_timeout"); break; end
        end
        at = cycle;
    endtask

    task automatic wait_rsp();
        int g;
        g = 0;
        while (rsp_q.size() > 0) begin
            @(negedge CLKin);
            g++;
            if (g > 50) begin flag_fail("rsp_timeout"); rsp_q.delete(); break; end
        end
    endtask

    initial begin
        int t, a0, key;
        RSTin = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        max_level = 0;
        repeat (3) @(negedge CLKin);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset_rsp_err",   32'(rsp_err),   32'd0);
        check("reset_wr_err",    32'(wr_err),    32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_wq_level",  32'(wq_level),  32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge CLKin);
        RSTin = 1'b0;

        // Single write then read
        issue(1, 3, 5, 8'hA5, 1);
        wait_idle(t);
        issue(0, 3, 5, 8'h00, 0);
        wait_rsp();

        // Back-to-back programming: first pop one edge after first acceptance
        for (int i = 0; i < 4; i++) begin
            issue(1, 4, i, 8'(8'h40 + i), 1);
            if (i == 0) a0 = last_acc;
        end
        wait_idle(t);
        check("b2b_busy_fall", 32'(t - a0), 32'(1 + 4 * WR_LAT));
        for (int i = 0; i < 4; i++) issue(0, 4, i, 8'h00, 0);
        wait_rsp();

        // Queue full: eight writes in a row must stall and reach full level
        max_level = 0;
        t = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1, 5, i, 8'($urandom), 1);
            t += last_stall;
        end
        check("qfull_stalled", 32'(t > 0), 32'd1);
        check("qfull_max_level", 32'(max_level), 32'(WQ));
        wait_idle(t);
        for (int i = 0; i < 8; i++) issue(0, 5, i, 8'h00, 0);
        wait_rsp();

        // Read ordering behind pending writes
        for (int i = 0; i < 3; i++) begin
            issue(1, 6, i, 8'(8'h60 + i), 1);
            if (i == 0) a0 = last_acc;
        end
        issue(0, 6, 2, 8'h00, 0);
        check("rd_order_accept", 32'(last_acc - a0), 32'(3 * WR_LAT + 2));
        wait_rsp();

        // Out-of-range rows and columns
        issue(1, 31, 5, 8'h5A, 1);
        issue(1, 3, 25, 8'h5B, 1);
        wait_idle(t);
        issue(0, 31, 5, 8'h00, 0);
        issue(0, 3, 25, 8'h00, 0);
        issue(0, 3, 5, 8'h00, 0);
        wait_rsp();

        // Reset in the middle of programming
        issue(1, 0, 0, 8'h11, 1);
        issue(1, 1, 1, 8'h22, 1);
        issue(1, 2, 2, 8'h33, 1);
        wait_idle(t);
        issue(1, 0, 0, 8'h3C, 0);
        issue(1, 1, 1, 8'h77, 0);
        issue(1, 2, 2, 8'h88, 0);
        @(negedge CLKin);
        #2 RSTin = 1'b1;
        #1;
        check("midreset_busy",      32'(busy),      32'd0);
        check("midreset_wq_level",  32'(wq_level),  32'd0);
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_wr_err",    32'(wr_err),    32'd0);
        repeat (2) @(negedge CLKin);
        RSTin = 1'b0;
        wr_exp_q.delete();
        for (int i = 0; i < 3; i++) issue(0, i, i, 8'h00, 0);
        wait_rsp();

        // Randomized traffic against the cell model
        for (int n = 0; n < 150; n++) begin
            int row, col;
            bit we;
            we = ($urandom_range(0, 1) == 1) || (written.size() == 0);
            if ($urandom_range(0, 9) == 0) begin
                row = $urandom_range(ROWS, 31);
                col = $urandom_range(0, 31);
            end else if (we) begin
                row = $urandom_range(0, ROWS - 1);
                col = $urandom_range(0, COLS - 1);
            end else begin
                key = written[$urandom_range(0, written.size() - 1)];
                row = key / 32;
                col = key % 32;
            end
            issue(we, row, col, 8'($urandom), 1);
            repeat ($urandom_range(0, 2)) @(negedge CLKin);
        end
        wait_idle(t);
        wait_rsp();
        repeat (3) @(negedge CLKin);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("wr_err_queue_drained", 32'(wr_exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
